// File: rtl/ika87ad_busmem_emu_if.sv
// CPU bus, loader, patch-table and write-log signals for the IKA87AD memory emulator.
// master = bench or CPU side, slave = emulator side.
interface ika87ad_busmem_emu_if #(
  parameter int MEM_AW = 9
);
  logic [15:0]       i_A;
  logic              i_RD_n;
  logic              i_WR_n;
  logic [7:0]        i_DO;
  logic [7:0]        o_DI;
  logic              o_DI_OE;
  logic              i_LOAD_EN;
  logic              i_LOAD_WE;
  logic [MEM_AW-1:0] i_LOAD_ADDR;
  logic [7:0]        i_LOAD_DATA;
  logic              i_PATCH_WE;
  logic [3:0]        i_PATCH_IDX;
  logic              i_PATCH_VALID;
  logic [15:0]       i_PATCH_ADDR;
  logic [7:0]        i_PATCH_DATA;
  logic              o_LOG_VALID;
  logic              i_LOG_READY;
  logic [15:0]       o_LOG_ADDR;
  logic [7:0]        o_LOG_DATA;
  logic              o_LOG_OVF;
  logic              i_LOG_CLR;

  modport master (
    output i_A, i_RD_n, i_WR_n, i_DO,
    input  o_DI, o_DI_OE,
    output i_LOAD_EN, i_LOAD_WE, i_LOAD_ADDR, i_LOAD_DATA,
    output i_PATCH_WE, i_PATCH_IDX, i_PATCH_VALID,
    output i_PATCH_ADDR, i_PATCH_DATA,
    input  o_LOG_VALID, o_LOG_ADDR, o_LOG_DATA, o_LOG_OVF,
    output i_LOG_READY, i_LOG_CLR
  );

  modport slave (
    input  i_A, i_RD_n, i_WR_n, i_DO,
    output o_DI, o_DI_OE,
    input  i_LOAD_EN, i_LOAD_WE, i_LOAD_ADDR, i_LOAD_DATA,
    input  i_PATCH_WE, i_PATCH_IDX, i_PATCH_VALID,
    input  i_PATCH_ADDR, i_PATCH_DATA,
    output o_LOG_VALID, o_LOG_ADDR, o_LOG_DATA, o_LOG_OVF,
    input  i_LOG_READY, i_LOG_CLR
  );
endinterface

// File: rtl/ika87ad_busmem_emu.sv
// External-bus memory emulator: RAM/ROM array, patch table, write-capture FIFO.
// Ports: i_EMUCLK, i_RESET_n (async, active low), bus (slave modport).
module ika87ad_busmem_emu #(
  parameter int          MEM_AW    = 9,
  parameter logic [15:0] ROM_TOP   = 16'h00FF,
  parameter int          NPATCH    = 8,
  parameter int          LOG_DEPTH = 16,
  parameter logic [7:0]  OPEN_BUS  = 8'hFF
) (
  input logic                  i_EMUCLK,
  input logic                  i_RESET_n,
  ika87ad_busmem_emu_if.slave  bus
);
  localparam int MEM_SZ = 1 << MEM_AW;
  localparam int LW     = $clog2(LOG_DEPTH);
  localparam int PW     = LW + 1;

  typedef enum logic {IDLE, WRACT} state_t;

  logic [7:0]  mem [MEM_SZ];
  logic        p_vld  [NPATCH];
  logic [15:0] p_addr [NPATCH];
  logic [7:0]  p_data [NPATCH];
  logic [23:0] fifo [LOG_DEPTH];

  state_t      state, nxt;
  logic        latch, commit;
  logic [15:0] wa;
  logic [7:0]  wd;
  logic [7:0]  rd_data, di_q;
  logic        oe_q, a_in, wr_in;
  logic [PW-1:0] wp, rp, cnt;
  logic        empty, full, do_pop, do_push, ovf_q;

  assign a_in  = ((32'(bus.i_A)) >> MEM_AW) == 32'd0;
  assign wr_in = ((32'(wa)) >> MEM_AW) == 32'd0;

  // Lowest valid index wins, so scan from the top down.
  always_comb begin
    rd_data = a_in ? mem[bus.i_A[MEM_AW-1:0]] : OPEN_BUS;
    for (int i = NPATCH - 1; i >= 0; i--)
      if (p_vld[i] && p_addr[i] == bus.i_A)
        rd_data = p_data[i];
  end

  always_ff @(posedge i_EMUCLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      di_q <= OPEN_BUS;
      oe_q <= 1'b0;
    end else if (!bus.i_RD_n && !bus.i_LOAD_EN && bus.i_WR_n) begin
      di_q <= rd_data;
      oe_q <= 1'b1;
    end else begin
      oe_q <= 1'b0;
    end
  end

  assign bus.o_DI    = di_q;
  assign bus.o_DI_OE = oe_q;

  always_ff @(posedge i_EMUCLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      for (int i = 0; i < NPATCH; i++) begin
        p_vld[i]  <= 1'b0;
        p_addr[i] <= '0;
        p_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NPATCH; i++) begin
        if (bus.i_PATCH_WE && bus.i_PATCH_IDX == 4'(i)) begin
          p_vld[i]  <= bus.i_PATCH_VALID;
          p_addr[i] <= bus.i_PATCH_ADDR;
          p_data[i] <= bus.i_PATCH_DATA;
        end
      end
    end
  end

  always_ff @(posedge i_EMUCLK or negedge i_RESET_n) begin
    if (!i_RESET_n) state <= IDLE;
    else            state <= nxt;
  end

  // The strobe edge that enters WRACT also captures, so a
  // one-cycle write strobe still commits a defined address.
  always_comb begin
    nxt    = state;
    latch  = 1'b0;
    commit = 1'b0;
    unique case (state)
      IDLE: begin
        if (!bus.i_WR_n && !bus.i_LOAD_EN) begin
          nxt   = WRACT;
          latch = 1'b1;
        end
      end
      WRACT: begin
        if (bus.i_LOAD_EN) begin
          nxt = IDLE;
        end else if (bus.i_WR_n) begin
          nxt    = IDLE;
          commit = 1'b1;
        end else begin
          latch = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_EMUCLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      wa <= '0;
      wd <= '0;
    end else if (latch) begin
      wa <= bus.i_A;
      wd <= bus.i_DO;
    end
  end

  // Array contents survive reset; loader and commit never coincide.
  always_ff @(posedge i_EMUCLK) begin
    if (bus.i_LOAD_EN && bus.i_LOAD_WE)
      mem[bus.i_LOAD_ADDR] <= bus.i_LOAD_DATA;
    else if (commit && wr_in && wa > ROM_TOP)
      mem[wa[MEM_AW-1:0]] <= wd;
  end

  assign cnt     = wp - rp;
  assign empty   = wp == rp;
  assign full    = cnt == PW'(LOG_DEPTH);
  assign do_pop  = bus.i_LOG_READY && !empty;
  assign do_push = commit && (!full || do_pop);

  always_ff @(posedge i_EMUCLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      wp    <= '0;
      rp    <= '0;
      ovf_q <= 1'b0;
    end else if (bus.i_LOG_CLR) begin
      wp    <= '0;
      rp    <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      if (commit && full && !do_pop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge i_EMUCLK) begin
    if (do_push && !bus.i_LOG_CLR)
      fifo[wp[LW-1:0]] <= {wa, wd};
  end

  assign bus.o_LOG_VALID = !empty;
  assign bus.o_LOG_OVF   = ovf_q;
  assign bus.o_LOG_ADDR  = fifo[rp[LW-1:0]][23:8];
  assign bus.o_LOG_DATA  = fifo[rp[LW-1:0]][7:0];
endmodule

// File: tb/tb_ika87ad_busmem_emu.sv
// Self-checking bench for ika87ad_busmem_emu.
// Directed vectors, hand sequences, then random ops vs a transaction model.
module tb_ika87ad_busmem_emu;
  localparam int MEM_AW = 9;
  localparam int NP     = 8;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ika87ad_busmem_emu_if #(.MEM_AW(MEM_AW)) bus();

  ika87ad_busmem_emu #(
    .MEM_AW(MEM_AW), .ROM_TOP(16'h00FF), .NPATCH(NP),
    .LOG_DEPTH(DEPTH), .OPEN_BUS(8'hFF)
  ) dut (
    .i_EMUCLK(clk),
    .i_RESET_n(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem_m [512];
  bit          pv_m [NP];
  logic [15:0] pa_m [NP];
  logic [7:0]  pd_m [NP];
  logic [23:0] q [$];
  bit          ovf_m;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  exp;
  } rv_t;
  rv_t tbl [7];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref_rd(logic [15:0] a);
    for (int i = 0; i < NP; i++)
      if (pv_m[i] && pa_m[i] == a) return pd_m[i];
    if (a < 16'h0200) return mem_m[a[8:0]];
    return 8'hFF;
  endfunction

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 3))
      0: return 16'($urandom_range(0, 16'h1FF));
      1: return 16'hFFF0 + 16'($urandom_range(0, 3));
      2: return 16'($urandom);
      default: return 16'h00F0 + 16'($urandom_range(0, 31));
    endcase
  endfunction

  task automatic model_commit(logic [15:0] a, logic [7:0] d);
    if (a > 16'h00FF && a < 16'h0200) mem_m[a[8:0]] = d;
    if (q.size() < DEPTH) q.push_back({a, d});
    else ovf_m = 1'b1;
  endtask

  task automatic load(logic [8:0] a, logic [7:0] d);
    bus.i_LOAD_EN = 1'b1;
    bus.i_LOAD_WE = 1'b1;
    bus.i_LOAD_ADDR = a;
    bus.i_LOAD_DATA = d;
    tick();
    mem_m[a] = d;
    bus.i_LOAD_WE = 1'b0;
    bus.i_LOAD_EN = 1'b0;
  endtask

  task automatic patch(logic [3:0] idx, bit v, logic [15:0] a, logic [7:0] d);
    bus.i_PATCH_WE = 1'b1;
    bus.i_PATCH_IDX = idx;
    bus.i_PATCH_VALID = v;
    bus.i_PATCH_ADDR = a;
    bus.i_PATCH_DATA = d;
    tick();
    bus.i_PATCH_WE = 1'b0;
    if (idx < NP) begin
      pv_m[idx] = v;
      pa_m[idx] = a;
      pd_m[idx] = d;
    end
  endtask

  task automatic rd(string nm, logic [15:0] a, logic [7:0] exp);
    bus.i_RD_n = 1'b0;
    bus.i_A = a;
    tick();
    bus.i_RD_n = 1'b1;
    chk({nm, " data"}, bus.o_DI, exp);
    chk({nm, " oe"}, bus.o_DI_OE, 1);
    tick();
    chk({nm, " oe off"}, bus.o_DI_OE, 0);
    chk({nm, " hold"}, bus.o_DI, exp);
  endtask

  task automatic wr(logic [15:0] a, logic [7:0] d);
    bus.i_WR_n = 1'b0;
    bus.i_A = a;
    bus.i_DO = d;
    tick();
    bus.i_WR_n = 1'b1;
    tick();
    model_commit(a, d);
  endtask

  task automatic chk_log(string nm);
    chk({nm, " valid"}, bus.o_LOG_VALID, q.size() != 0);
    chk({nm, " ovf"}, bus.o_LOG_OVF, ovf_m);
    if (q.size() != 0)
      chk({nm, " head"}, {bus.o_LOG_ADDR, bus.o_LOG_DATA}, q[0]);
  endtask

  task automatic pop(string nm);
    chk_log(nm);
    bus.i_LOG_READY = 1'b1;
    tick();
    bus.i_LOG_READY = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic clr();
    bus.i_LOG_CLR = 1'b1;
    tick();
    bus.i_LOG_CLR = 1'b0;
    q.delete();
    ovf_m = 1'b0;
  endtask

  initial begin
    bus.i_A = '0;
    bus.i_RD_n = 1'b1;
    bus.i_WR_n = 1'b1;
    bus.i_DO = '0;
    bus.i_LOAD_EN = 1'b0;
    bus.i_LOAD_WE = 1'b0;
    bus.i_LOAD_ADDR = '0;
    bus.i_LOAD_DATA = '0;
    bus.i_PATCH_WE = 1'b0;
    bus.i_PATCH_IDX = '0;
    bus.i_PATCH_VALID = 1'b0;
    bus.i_PATCH_ADDR = '0;
    bus.i_PATCH_DATA = '0;
    bus.i_LOG_READY = 1'b0;
    bus.i_LOG_CLR = 1'b0;
    for (int i = 0; i < NP; i++) begin
      pv_m[i] = 1'b0;
      pa_m[i] = '0;
      pd_m[i] = '0;
    end
    ovf_m = 1'b0;

    repeat (2) tick();
    chk("reset di", bus.o_DI, 8'hFF);
    chk("reset oe", bus.o_DI_OE, 0);
    chk("reset valid", bus.o_LOG_VALID, 0);
    chk("reset ovf", bus.o_LOG_OVF, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 512; i++) load(9'(i), 8'($urandom));
    load(9'h000, 8'hAA);
    load(9'h001, 8'hBB);
    load(9'h002, 8'hCC);
    load(9'h003, 8'hDD);
    load(9'h010, 8'h10);
    load(9'h0FF, 8'hC3);
    load(9'h100, 8'h3C);
    load(9'h1FF, 8'h5A);
    load(9'h160, 8'h44);

    rd("rd 002", 16'h0002, 8'hCC);

    tbl[0] = '{16'h0000, 8'hAA};
    tbl[1] = '{16'h0001, 8'hBB};
    tbl[2] = '{16'h0003, 8'hDD};
    tbl[3] = '{16'h00FF, 8'hC3};
    tbl[4] = '{16'h0100, 8'h3C};
    tbl[5] = '{16'h01FF, 8'h5A};
    tbl[6] = '{16'h0200, 8'hFF};
    for (int i = 0; i < 7; i++) rd($sformatf("tbl%0d", i), tbl[i].a, tbl[i].exp);

    patch(4'd0, 1'b1, 16'hFFF0, 8'hAD);
    patch(4'd3, 1'b1, 16'hFFF0, 8'h11);
    rd("patch lo idx", 16'hFFF0, 8'hAD);
    patch(4'd0, 1'b0, 16'hFFF0, 8'hAD);
    rd("patch idx3", 16'hFFF0, 8'h11);
    rd("open bus", 16'h1234, 8'hFF);
    patch(4'd9, 1'b1, 16'h1234, 8'h42);
    rd("idx ignored", 16'h1234, 8'hFF);

    bus.i_PATCH_WE = 1'b1;
    bus.i_PATCH_IDX = 4'd1;
    bus.i_PATCH_VALID = 1'b1;
    bus.i_PATCH_ADDR = 16'h0002;
    bus.i_PATCH_DATA = 8'h77;
    bus.i_RD_n = 1'b0;
    bus.i_A = 16'h0002;
    tick();
    bus.i_PATCH_WE = 1'b0;
    bus.i_RD_n = 1'b1;
    pv_m[1] = 1'b1;
    pa_m[1] = 16'h0002;
    pd_m[1] = 8'h77;
    chk("patch same cyc", bus.o_DI, 8'hCC);
    tick();
    rd("patch new", 16'h0002, 8'h77);
    patch(4'd1, 1'b0, 16'h0002, 8'h77);

    wr(16'h0010, 8'h55);
    wr(16'h0150, 8'h66);
    rd("rom prot", 16'h0010, 8'h10);
    rd("ram wr", 16'h0150, 8'h66);
    chk("log0", {bus.o_LOG_ADDR, bus.o_LOG_DATA}, 24'h001055);
    pop("log0");
    chk("log1", {bus.o_LOG_ADDR, bus.o_LOG_DATA}, 24'h015066);
    pop("log1");
    chk("log empty", bus.o_LOG_VALID, 0);
    pop("pop empty");
    wr(16'h00FF, 8'h01);
    wr(16'h0100, 8'h02);
    wr(16'h0200, 8'h03);
    rd("rom top", 16'h00FF, 8'hC3);
    rd("ram bot", 16'h0100, 8'h02);
    for (int i = 0; i < 3; i++) pop($sformatf("edge log%0d", i));

    bus.i_WR_n = 1'b0;
    bus.i_A = 16'h0120;
    bus.i_DO = 8'h01;
    tick();
    bus.i_A = 16'h0121;
    bus.i_DO = 8'h02;
    tick();
    bus.i_WR_n = 1'b1;
    bus.i_A = 16'h0000;
    bus.i_DO = 8'hEE;
    tick();
    model_commit(16'h0121, 8'h02);
    pop("last latch");
    rd("last latch rd", 16'h0121, 8'h02);

    bus.i_RD_n = 1'b0;
    bus.i_WR_n = 1'b0;
    bus.i_A = 16'h0140;
    bus.i_DO = 8'h77;
    tick();
    chk("rdwr oe", bus.o_DI_OE, 0);
    bus.i_RD_n = 1'b1;
    bus.i_WR_n = 1'b1;
    tick();
    model_commit(16'h0140, 8'h77);
    rd("rdwr data", 16'h0140, 8'h77);
    pop("rdwr log");

    bus.i_WR_n = 1'b0;
    bus.i_A = 16'h0130;
    bus.i_DO = 8'h09;
    tick();
    bus.i_WR_n = 1'b1;
    bus.i_LOAD_EN = 1'b1;
    tick();
    bus.i_LOAD_EN = 1'b0;
    tick();
    chk_log("load abort");
    rd("load abort rd", 16'h0130, mem_m[9'h130]);

    clr();
    for (int i = 0; i < 17; i++) wr(16'h0180 + 16'(i), 8'(i));
    chk("ovf17", bus.o_LOG_OVF, 1);
    chk_log("ovf17");
    clr();
    chk("clr valid", bus.o_LOG_VALID, 0);
    chk("clr ovf", bus.o_LOG_OVF, 0);

    for (int i = 0; i < 16; i++) wr(16'h0180 + 16'(i), 8'(i));
    chk_log("full16");
    bus.i_WR_n = 1'b0;
    bus.i_A = 16'h0190;
    bus.i_DO = 8'hF0;
    tick();
    bus.i_WR_n = 1'b1;
    bus.i_LOG_READY = 1'b1;
    tick();
    bus.i_LOG_READY = 1'b0;
    void'(q.pop_front());
    model_commit(16'h0190, 8'hF0);
    chk("pushpop head", {bus.o_LOG_ADDR, bus.o_LOG_DATA}, 24'h018101);
    chk("pushpop ovf", bus.o_LOG_OVF, 0);
    for (int i = 0; i < 16; i++) pop($sformatf("drain%0d", i));
    chk("drained", bus.o_LOG_VALID, 0);

    bus.i_WR_n = 1'b0;
    bus.i_A = 16'h0170;
    bus.i_DO = 8'h5C;
    tick();
    bus.i_WR_n = 1'b1;
    bus.i_LOG_CLR = 1'b1;
    bus.i_LOG_READY = 1'b1;
    tick();
    bus.i_LOG_CLR = 1'b0;
    bus.i_LOG_READY = 1'b0;
    mem_m[9'h170] = 8'h5C;
    chk("clr over push", bus.o_LOG_VALID, 0);
    rd("clr wr rd", 16'h0170, 8'h5C);

    patch(4'd2, 1'b1, 16'hFFF1, 8'h21);
    rd("pre rst", 16'h0000, 8'hAA);
    wr(16'h0150, 8'h67);
    bus.i_WR_n = 1'b0;
    bus.i_A = 16'h0160;
    bus.i_DO = 8'h99;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst di", bus.o_DI, 8'hFF);
    chk("async rst oe", bus.o_DI_OE, 0);
    chk("async rst valid", bus.o_LOG_VALID, 0);
    chk("async rst ovf", bus.o_LOG_OVF, 0);
    bus.i_WR_n = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    q.delete();
    ovf_m = 1'b0;
    for (int i = 0; i < NP; i++) pv_m[i] = 1'b0;
    chk_log("after rst");
    rd("no commit", 16'h0160, 8'h44);
    rd("patch rst", 16'hFFF1, 8'hFF);

    for (int n = 0; n < 400; n++) begin
      logic [15:0] a;
      a = rand_addr();
      case ($urandom_range(0, 9))
        0, 1, 2, 3: rd("rand rd", a, ref_rd(a));
        4, 5: wr(a, 8'($urandom));
        6: pop("rand pop");
        7: load(9'($urandom), 8'($urandom));
        8: patch(4'($urandom_range(0, 11)), 1'($urandom), a, 8'($urandom));
        default: chk_log("rand log");
      endcase
    end
    chk_log("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
